maxima_uart_tx: RTL and testbench

MAXIMA_UART_TX -- requirements
Module: maxima_uart_tx

---
 rtl/shazam_pkg.sv | 30 +++
 rtl/uart_tx_byte.sv | 74 +++++++
 rtl/maxima_uart_tx.sv | 209 ++++++++++++++++++++
 tb/tb_maxima_uart_tx.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/shazam_pkg.sv
// -----------------------------------------------------------------------------
// shazam_pkg
// Shared constants and types for the maxima reporting path.
//   NUM_MAXIMAS      : number of peak bins in one maxima set
//   MAXIMA_W         : width of one peak bin
//   BYTES_PER_MAXIMA : each maximum goes on the wire as a 32-bit word
//   FRAME_SYNC       : first byte of every frame, used by the host to align
//   BYTE_CNT_W       : width of the frame byte counter
//   tx_state_t       : frame sequencer states
//   maxima_set_t     : one complete maxima set, index 0..NUM_MAXIMAS-1
// -----------------------------------------------------------------------------
package shazam_pkg;

  localparam int         NUM_MAXIMAS      = 16;
  localparam int         MAXIMA_W         = 25;
  localparam int         BYTES_PER_MAXIMA = 4;
  localparam logic [7:0] FRAME_SYNC       = 8'hA5;
  localparam int         BYTE_CNT_W       = 7;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    DONE
  } tx_state_t;

  typedef logic [NUM_MAXIMAS-1:0][MAXIMA_W-1:0] maxima_set_t;

endpackage

// File: rtl/uart_tx_byte.sv
// -----------------------------------------------------------------------------
// uart_tx_byte
// 8N1 byte serializer: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1),
// each held for exactly CLKS_PER_BIT clock cycles. Line idles high.
//
// Handshake: a byte is accepted on the edge where start && ready. ready is high
// while idle and also during the final cycle of the stop bit, so a caller that
// keeps feeding bytes gets them back-to-back with no idle gap.
//
// Ports
//   clk      : system clock
//   reset    : synchronous, active-low reset
//   start    : request to send data (accepted when ready)
//   data     : byte to send
//   ready    : engine can accept a byte on this edge
//   bit_done : last cycle of the bit currently on the line
//   bit_idx  : bit on the line: 0 = start, 1..8 = data 0..7, 9 = stop
//   tx       : serial output
// -----------------------------------------------------------------------------
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       ready,
  output logic       bit_done,
  output logic [3:0] bit_idx,
  output logic       tx
);

  localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]       IDX_STOP = 4'd9;

  logic             active;
  logic [CNT_W-1:0] clk_cnt;
  // Whole character including start/stop bits; bit 0 is always on the line.
  // Ones shift in from the top, so the line rests high after the stop bit.
  logic [9:0]       shift;

  assign bit_done = active && (clk_cnt == CNT_LAST);
  assign ready    = !active || (bit_done && (bit_idx == IDX_STOP));
  assign tx       = shift[0];

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      active  <= 1'b0;
      clk_cnt <= '0;
      bit_idx <= '0;
      shift   <= '1;
    end else if (start && ready) begin
      active  <= 1'b1;
      clk_cnt <= '0;
      bit_idx <= '0;
      shift   <= {1'b1, data, 1'b0};
    end else if (bit_done) begin
      clk_cnt <= '0;
      shift   <= {1'b1, shift[9:1]};
      if (bit_idx == IDX_STOP) begin
        active  <= 1'b0;
        bit_idx <= '0;
      end else begin
        bit_idx <= bit_idx + 4'd1;
      end
    end else if (active) begin
      clk_cnt <= clk_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/maxima_uart_tx.sv
// -----------------------------------------------------------------------------
// maxima_uart_tx
// Ships each new maxima set from shazam_core to a host over a UART.
//
// Frame: FRAME_SYNC, then maxima 0..15, each zero-extended to 32 bits and sent
// MSB byte first, then (optional) an XOR checksum of the 64 payload bytes.
// A 0->1 transition on maximas_found_active while idle snapshots the set; the
// sync start bit goes out on the following edge. Transitions that arrive while
// a frame is in flight are discarded and reported on dropped.
//
// Build option
//   MAXIMA_TX_CHECKSUM_EN : when defined, append the checksum byte (66 bytes);
//                           otherwise the frame ends after maxima 15 byte 0.
//
// Ports
//   clk                  : system clock (MAX10_CLK1_50 domain)
//   reset                : synchronous, active-low reset
//   maximas              : 16 x 25-bit peak bins
//   maximas_found_active : maxima-set-valid level
//   uart_tx              : serial line, 8N1, LSB first, idle high
//   busy                 : frame in flight (snapshot edge through DONE)
//   frame_done           : one-cycle pulse after the last stop bit
//   dropped              : one-cycle pulse for a set that arrived while busy
// -----------------------------------------------------------------------------
module maxima_uart_tx
  import shazam_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_MAXIMAS-1:0][MAXIMA_W-1:0] maximas,
  input  logic                                 maximas_found_active,
  output logic                                 uart_tx,
  output logic                                 busy,
  output logic                                 frame_done,
  output logic                                 dropped
);

  localparam int NUM_PAYLOAD = NUM_MAXIMAS * BYTES_PER_MAXIMA;
`ifdef MAXIMA_TX_CHECKSUM_EN
  localparam int NUM_BYTES = NUM_PAYLOAD + 2;
`else
  localparam int NUM_BYTES = NUM_PAYLOAD + 1;
`endif
  localparam logic [BYTE_CNT_W-1:0] BYTES_TOTAL  = BYTE_CNT_W'(NUM_BYTES);
  localparam logic [BYTE_CNT_W-1:0] PAYLOAD_LAST = BYTE_CNT_W'(NUM_PAYLOAD);
  localparam logic [3:0]            IDX_DATA7    = 4'd8;

  tx_state_t state, state_next;

  logic                  active_q;
  logic                  rise;
  maxima_set_t           snap;
  logic [BYTE_CNT_W-1:0] byte_cnt;   // bytes handed to the serializer so far
  logic                  more_bytes;
  logic                  load;
  logic [7:0]            byte_data;
  logic [NUM_PAYLOAD*8-1:0] payload;
  logic [5:0]            payload_sel;
  logic                  payload_load;

  logic       eng_ready;
  logic       eng_bit_done;
  logic [3:0] eng_bit_idx;

`ifdef MAXIMA_TX_CHECKSUM_EN
  logic [7:0] checksum;
`endif

  // ---------------------------------------------------------------------------
  // Edge detection. The previous-value register keeps sampling during reset,
  // so a level already high at release is not mistaken for a new set.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    active_q <= maximas_found_active;
  end

  assign rise = maximas_found_active && !active_q;

  // ---------------------------------------------------------------------------
  // Snapshot of the maxima set, taken only on an accepted edge in IDLE.
  // ---------------------------------------------------------------------------
  // NOTE: pure data storage is left without reset; it is always written
  // before it is read, and skipping the reset keeps it off the reset tree.
  always_ff @(posedge clk) begin
    if ((state == IDLE) && rise) begin
      snap <= maximas;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame sequencer: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  assign more_bytes = (byte_cnt < BYTES_TOTAL);

  // ---------------------------------------------------------------------------
  // Frame sequencer: next state. The states track what the serializer has on
  // the line; START also covers the single loading cycle before the sync byte.
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default at the top of the block,
  // so no path can leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (rise) state_next = START;
      START: if (eng_bit_done) state_next = DATA;
      DATA:  if (eng_bit_done && (eng_bit_idx == IDX_DATA7)) state_next = STOP;
      STOP:  if (eng_bit_done) state_next = more_bytes ? START : DONE;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Frame sequencer: outputs. The next byte is handed over during the last
  // cycle of the previous stop bit, which keeps bytes back-to-back.
  // ---------------------------------------------------------------------------
  always_comb begin
    busy       = (state != IDLE);
    frame_done = (state == DONE);
    load       = eng_ready && ((state == START) || ((state == STOP) && more_bytes));
  end

  // ---------------------------------------------------------------------------
  // Byte selection. Maximum m occupies payload bytes 4m..4m+3, MSB first; the
  // flat vector puts payload byte 0 in its top byte.
  // ---------------------------------------------------------------------------
  always_comb begin
    payload = '0;
    for (int m = 0; m < NUM_MAXIMAS; m++) begin
      payload[(NUM_MAXIMAS-1-m)*32 +: 32] = 32'(snap[m]);
    end
  end

  // Payload byte j = byte_cnt - 1 lives at byte position 63 - j = ~j.
  assign payload_sel  = 6'(byte_cnt - 7'd1);
  assign payload_load = load && (byte_cnt != '0) && (byte_cnt <= PAYLOAD_LAST);

  always_comb begin
    byte_data = payload[{~payload_sel, 3'b000} +: 8];
    if (byte_cnt == '0) begin
      byte_data = FRAME_SYNC;
    end
`ifdef MAXIMA_TX_CHECKSUM_EN
    else if (byte_cnt > PAYLOAD_LAST) begin
      byte_data = checksum;
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // Byte counter, checksum and dropped pulse
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      byte_cnt <= '0;
      dropped  <= 1'b0;
    end else begin
      dropped <= rise && (state != IDLE);
      if ((state == IDLE) && rise) begin
        byte_cnt <= '0;
      end else if (load) begin
        byte_cnt <= byte_cnt + 7'd1;
      end
    end
  end

`ifdef MAXIMA_TX_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      checksum <= '0;
    end else if ((state == IDLE) && rise) begin
      checksum <= '0;
    end else if (payload_load) begin
      checksum <= checksum ^ byte_data;
    end
  end
`else
  // Only the checksum accumulator consumes this qualifier.
  logic unused_payload_load;
  assign unused_payload_load = payload_load;
`endif

  // ---------------------------------------------------------------------------
  // Serializer
  // ---------------------------------------------------------------------------
  uart_tx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_byte (
    .clk      (clk),
    .reset    (reset),
    .start    (load),
    .data     (byte_data),
    .ready    (eng_ready),
    .bit_done (eng_bit_done),
    .bit_idx  (eng_bit_idx),
    .tx       (uart_tx)
  );

endmodule

// File: tb/tb_maxima_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_maxima_uart_tx
// Directed bench for maxima_uart_tx at CLKS_PER_BIT = 4. Expected frame bytes
// are pushed to a queue when a set is launched; a UART receiver model decodes
// the line at mid-bit and compares each byte against the head of the queue.
// Honors MAXIMA_TX_CHECKSUM_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_maxima_uart_tx;
  import shazam_pkg::*;

  localparam int CLKS = 4;
`ifdef MAXIMA_TX_CHECKSUM_EN
  localparam int FRAME_BYTES = 66;
`else
  localparam int FRAME_BYTES = 65;
`endif

  logic        clk;
  logic        reset;
  maxima_set_t maximas;
  logic        maximas_found_active;
  logic        uart_tx;
  logic        busy;
  logic        frame_done;
  logic        dropped;

  maxima_uart_tx #(
    .CLKS_PER_BIT (CLKS)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .maximas              (maximas),
    .maximas_found_active (maximas_found_active),
    .uart_tx              (uart_tx),
    .busy                 (busy),
    .frame_done           (frame_done),
    .dropped              (dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  int  rx_count   = 0;
  int  rx_unexp   = 0;
  bit  rx_discard = 1'b0;
  int  fd_cnt     = 0;
  int  dr_cnt     = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse counters, sampled away from the active edge.
  always @(negedge clk) begin
    if (frame_done === 1'b1) fd_cnt++;
    if (dropped === 1'b1) dr_cnt++;
  end

  // UART receiver: start detected on the first low sample, then each bit is
  // sampled in its second cycle.
  always begin : rx_proc
    logic [7:0] b;
    logic       sbit;
    logic       pbit;
    @(negedge clk);
    if (uart_tx === 1'b0) begin
      repeat (CLKS / 2 - 1) @(negedge clk);
      sbit = uart_tx;
      for (int k = 0; k < 8; k++) begin
        repeat (CLKS) @(negedge clk);
        b[k] = uart_tx;
      end
      repeat (CLKS) @(negedge clk);
      pbit = uart_tx;
      if (!rx_discard) begin
        check("rx_start_bit", 32'(sbit), 32'd0);
        check("rx_stop_bit", 32'(pbit), 32'd1);
        if (exp_q.size() == 0) rx_unexp++;
        else check("rx_byte", 32'(b), 32'(exp_q.pop_front()));
      end
      rx_count++;
    end
  end

  // Reference frame: sync, 32-bit zero-extended maxima MSB byte first, checksum.
  task automatic push_frame(input maxima_set_t m);
    logic [31:0] w;
    logic [7:0]  b;
    logic [7:0]  chk;
    chk = 8'h00;
    exp_q.push_back(8'hA5);
    for (int i = 0; i < NUM_MAXIMAS; i++) begin
      w = 32'(m[i]);
      for (int j = 3; j >= 0; j--) begin
        b = w[j*8 +: 8];
        exp_q.push_back(b);
        chk = chk ^ b;
      end
    end
`ifdef MAXIMA_TX_CHECKSUM_EN
    exp_q.push_back(chk);
`endif
  endtask

  function automatic maxima_set_t rand_set();
    maxima_set_t m;
    for (int i = 0; i < NUM_MAXIMAS; i++) m[i] = MAXIMA_W'($urandom);
    return m;
  endfunction

  // Presents a set with a rising valid; returns at the negedge after the
  // snapshot edge.
  task automatic start_frame(input maxima_set_t m);
    @(negedge clk);
    maximas = m;
    maximas_found_active = 1'b1;
    push_frame(m);
    @(negedge clk);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (busy === 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(busy), 32'd0);
    repeat (8) @(negedge clk);
  endtask

  initial begin : main
    maxima_set_t m;
    int n;
    int fd0, dr0, rx0, un0;

    reset = 1'b0;
    maximas_found_active = 1'b0;
    maximas = '0;
    repeat (3) @(negedge clk);
    check("reset_uart_tx", 32'(uart_tx), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_frame_done", 32'(frame_done), 32'd0);
    check("reset_dropped", 32'(dropped), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Test 1: maxima k = k+1; timing of start bit, busy length, single done.
    for (int k = 0; k < NUM_MAXIMAS; k++) m[k] = MAXIMA_W'(k + 1);
    fd0 = fd_cnt; dr0 = dr_cnt; rx0 = rx_count; un0 = rx_unexp;
    start_frame(m);
    check("t1_busy_at_snapshot", 32'(busy), 32'd1);
    check("t1_idle_line_at_snapshot", 32'(uart_tx), 32'd1);
    maximas_found_active = 1'b0;
    @(negedge clk);
    check("t1_start_bit_next_edge", 32'(uart_tx), 32'd0);
    n = 0;
    while (busy === 1'b1 && n < 4000) begin
      n++;
      @(negedge clk);
    end
    check("t1_busy_cycles_from_start_bit", 32'(n), 32'(FRAME_BYTES * 10 * CLKS + 1));
    repeat (8) @(negedge clk);
    check("t1_frame_done_pulses", 32'(fd_cnt - fd0), 32'd1);
    check("t1_rx_bytes", 32'(rx_count - rx0), 32'(FRAME_BYTES));
    check("t1_queue_drained", 32'(exp_q.size()), 32'd0);
    check("t1_unexpected_bytes", 32'(rx_unexp - un0), 32'd0);
    check("t1_dropped", 32'(dr_cnt - dr0), 32'd0);

    // Test 2: zero-extension and MSB-first order.
    m = '0;
    m[0] = 25'h1FFFFFF;
    rx0 = rx_count;
    start_frame(m);
    maximas_found_active = 1'b0;
    wait_idle("t2_idle_timeout", 4000);
    check("t2_rx_bytes", 32'(rx_count - rx0), 32'(FRAME_BYTES));
    check("t2_queue_drained", 32'(exp_q.size()), 32'd0);

    // Test 3: second edge 100 cycles into the frame is dropped.
    fd0 = fd_cnt; dr0 = dr_cnt; rx0 = rx_count; un0 = rx_unexp;
    start_frame(rand_set());
    maximas_found_active = 1'b0;
    repeat (98) @(negedge clk);
    maximas = rand_set();
    maximas_found_active = 1'b1;
    @(negedge clk);
    maximas_found_active = 1'b0;
    wait_idle("t3_idle_timeout", 4000);
    repeat (200) @(negedge clk);
    check("t3_dropped_pulses", 32'(dr_cnt - dr0), 32'd1);
    check("t3_frame_done_pulses", 32'(fd_cnt - fd0), 32'd1);
    check("t3_rx_bytes", 32'(rx_count - rx0), 32'(FRAME_BYTES));
    check("t3_queue_drained", 32'(exp_q.size()), 32'd0);
    check("t3_unexpected_bytes", 32'(rx_unexp - un0), 32'd0);

    // Test 4: maximas churn every cycle, valid held high for 5000 cycles.
    fd0 = fd_cnt; dr0 = dr_cnt; rx0 = rx_count;
    start_frame(rand_set());
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      maximas = rand_set();
    end
    maximas_found_active = 1'b0;
    wait_idle("t4_idle_timeout", 4000);
    check("t4_frame_done_pulses", 32'(fd_cnt - fd0), 32'd1);
    check("t4_rx_bytes", 32'(rx_count - rx0), 32'(FRAME_BYTES));
    check("t4_queue_drained", 32'(exp_q.size()), 32'd0);
    check("t4_dropped", 32'(dr_cnt - dr0), 32'd0);

    // Test 5: reset during the data bits of byte 10, then a fresh frame.
    fd0 = fd_cnt;
    start_frame(rand_set());
    maximas_found_active = 1'b0;
    repeat (410) @(negedge clk);
    check("t5_busy_before_abort", 32'(busy), 32'd1);
    exp_q.delete();
    rx_discard = 1'b1;
    reset = 1'b0;
    @(negedge clk);
    check("t5_abort_uart_tx", 32'(uart_tx), 32'd1);
    check("t5_abort_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (60) @(negedge clk);
    check("t5_no_resume", 32'(busy), 32'd0);
    rx_discard = 1'b0;
    rx0 = rx_count; un0 = rx_unexp;
    start_frame(rand_set());
    maximas_found_active = 1'b0;
    wait_idle("t5_idle_timeout", 4000);
    check("t5_frame_done_pulses", 32'(fd_cnt - fd0), 32'd1);
    check("t5_rx_bytes", 32'(rx_count - rx0), 32'(FRAME_BYTES));
    check("t5_queue_drained", 32'(exp_q.size()), 32'd0);
    check("t5_unexpected_bytes", 32'(rx_unexp - un0), 32'd0);

    // Test 6: valid held high through reset does not start a frame.
    fd0 = fd_cnt; rx0 = rx_count;
    @(negedge clk);
    maximas_found_active = 1'b1;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (30) @(negedge clk);
    check("t6_busy_after_release", 32'(busy), 32'd0);
    check("t6_no_frame_done", 32'(fd_cnt - fd0), 32'd0);
    check("t6_no_rx_bytes", 32'(rx_count - rx0), 32'd0);
    maximas_found_active = 1'b0;
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #3ms;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
